// File: rtl/sort_pkg.sv
// sort_pkg: shared FSM encoding and sizing helper for the sequential bubble sorter
package sort_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int sw_width(input int depth);
    return $clog2(depth * (depth - 1) / 2 + 1);
  endfunction
endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: one compare-exchange cell; equal operands never swap
module sort_cmp_swap #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             desc,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             swap
);
  always_comb begin
    swap = desc ? (a < b) : (a > b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end
endmodule

// File: rtl/bubble_sort_seq.sv
// bubble_sort_seq: in-place bubble sorter, one compare-swap per clock with early exit
module bubble_sort_seq
  import sort_pkg::*;
#(
  parameter  int WIDTH = 5,
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int SW    = sw_width(DEPTH)
) (
  input  logic             clockcito,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] dato,
  input  logic [PW-1:0]    pos,
  input  logic             almacenar,
  input  logic             ordenar,
  input  logic             descendente,
  output logic [WIDTH-1:0] resultado,
  output logic             ocupado,
  output logic             listo,
  output logic [SW-1:0]    intercambios
);
  localparam logic [PW-1:0] ONE   = PW'(1);
  localparam logic [PW-1:0] LAST0 = PW'(DEPTH - 2);
  localparam logic [PW:0]   DEP   = (PW + 1)'(DEPTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q [DEPTH];
  logic [WIDTH-1:0] vec_d [DEPTH];
  logic [PW-1:0]    p_q, p_d, j_q, j_d, j_nx;
  logic             swp_q, swp_d, desc_q, desc_d;
  logic [SW-1:0]    intercambios_q, intercambios_d;
  logic [WIDTH-1:0] resultado_q, resultado_d, lo, hi;
  logic             ocupado_q, ocupado_d, listo_q, listo_d, swap, in_range;
  assign j_nx     = j_q + ONE;
  assign in_range = {1'b0, pos} < DEP;
  sort_cmp_swap #(.WIDTH(WIDTH)) u_cmp (
    .a   (vec_q[j_q]),
    .b   (vec_q[j_nx]),
    .desc(desc_q),
    .lo  (lo),
    .hi  (hi),
    .swap(swap)
  );
  always_comb begin
    state_d        = state_q;
    vec_d          = vec_q;
    p_d            = p_q;
    j_d            = j_q;
    swp_d          = swp_q;
    desc_d         = desc_q;
    intercambios_d = intercambios_q;
    if (state_q == S_IDLE) begin
      if (almacenar) begin
        if (in_range) vec_d[pos] = dato;
      end else if (ordenar) begin
        state_d        = S_SORT;
        p_d            = '0;
        j_d            = '0;
        swp_d          = 1'b0;
        intercambios_d = '0;
        desc_d         = descendente;
      end
    end else if (state_q == S_SORT) begin
      vec_d[j_q]  = lo;
      vec_d[j_nx] = hi;
      if (swap) begin
        swp_d          = 1'b1;
        intercambios_d = intercambios_q + SW'(1);
      end
      // pass boundary shrinks by one each pass; the swap of this cycle counts toward the pass
      if (j_q == LAST0 - p_q) begin
        if (!swp_d || p_q == LAST0) begin
          state_d = S_DONE;
        end else begin
          p_d   = p_q + ONE;
          j_d   = '0;
          swp_d = 1'b0;
        end
      end else begin
        j_d = j_nx;
      end
    end else begin
      state_d = S_IDLE;
    end
    ocupado_d   = state_d != S_IDLE;
    listo_d     = state_q == S_DONE;
    resultado_d = in_range ? vec_d[pos] : '0;
  end
  always_ff @(posedge clockcito or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      vec_q          <= '{default: '0};
      p_q            <= '0;
      j_q            <= '0;
      swp_q          <= 1'b0;
      desc_q         <= 1'b0;
      intercambios_q <= '0;
      resultado_q    <= '0;
      ocupado_q      <= 1'b0;
      listo_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      vec_q          <= vec_d;
      p_q            <= p_d;
      j_q            <= j_d;
      swp_q          <= swp_d;
      desc_q         <= desc_d;
      intercambios_q <= intercambios_d;
      resultado_q    <= resultado_d;
      ocupado_q      <= ocupado_d;
      listo_q        <= listo_d;
    end
  end
  assign resultado    = resultado_q;
  assign ocupado      = ocupado_q;
  assign listo        = listo_q;
  assign intercambios = intercambios_q;
endmodule

// File: tb/tb_bubble_sort_seq.sv
// tb_bubble_sort_seq: scoreboard bench for two sorter configurations (5x16 and 8x5)
module tb_bubble_sort_seq;
  typedef struct {
    bit    done;
    int    val;
    int    lat;
    string nm;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, errors = 0, ta0 = 0, tb0 = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [4:0] a_dato = '0, a_res;
  logic [3:0] a_pos = '0;
  logic       a_alm = 0, a_ord = 0, a_desc = 0, a_ocu, a_lis, ard = 0, ard_v = 0;
  logic [6:0] a_cnt;
  logic [7:0] b_dato = '0, b_res;
  logic [2:0] b_pos = '0;
  logic       b_alm = 0, b_ord = 0, b_desc = 0, b_ocu, b_lis, brd = 0, brd_v = 0;
  logic [3:0] b_cnt;
  bubble_sort_seq #(.WIDTH(5), .DEPTH(16)) dut_a (
    .clockcito(clk), .reset_n(rst_n), .dato(a_dato), .pos(a_pos), .almacenar(a_alm),
    .ordenar(a_ord), .descendente(a_desc), .resultado(a_res), .ocupado(a_ocu),
    .listo(a_lis), .intercambios(a_cnt)
  );
  bubble_sort_seq #(.WIDTH(8), .DEPTH(5)) dut_b (
    .clockcito(clk), .reset_n(rst_n), .dato(b_dato), .pos(b_pos), .almacenar(b_alm),
    .ordenar(b_ord), .descendente(b_desc), .resultado(b_res), .ocupado(b_ocu),
    .listo(b_lis), .intercambios(b_cnt)
  );
  always @(posedge clk) begin
    ard_v <= ard;
    brd_v <= brd;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask
  // monitors: pop the scoreboard whenever a read result or a listo pulse appears
  always @(negedge clk) begin
    if (ard_v) begin
      if (qa.size() == 0 || qa[0].done) chk("a_unexpected_read", 1, 0);
      else begin
        ea = qa.pop_front();
        chk(ea.nm, 32'(a_res), ea.val);
      end
    end
    if (a_lis) begin
      if (qa.size() == 0 || !qa[0].done) chk("a_unexpected_listo", 1, 0);
      else begin
        ea = qa.pop_front();
        chk({ea.nm, "_swaps"}, 32'(a_cnt), ea.val);
        if (ea.lat >= 0) chk({ea.nm, "_latency"}, cyc - ta0, ea.lat);
      end
    end
  end
  always @(negedge clk) begin
    if (brd_v) begin
      if (qb.size() == 0 || qb[0].done) chk("b_unexpected_read", 1, 0);
      else begin
        eb = qb.pop_front();
        chk(eb.nm, 32'(b_res), eb.val);
      end
    end
    if (b_lis) begin
      if (qb.size() == 0 || !qb[0].done) chk("b_unexpected_listo", 1, 0);
      else begin
        eb = qb.pop_front();
        chk({eb.nm, "_swaps"}, 32'(b_cnt), eb.val);
        if (eb.lat >= 0) chk({eb.nm, "_latency"}, cyc - tb0, eb.lat);
      end
    end
  end
  task automatic a_write(input int p, input int d);
    a_pos = 4'(p); a_dato = 5'(d); a_alm = 1;
    @(posedge clk); #1 a_alm = 0;
  endtask
  task automatic a_read(input int p, input int exp, input string nm);
    a_pos = 4'(p); ard = 1;
    qa.push_back('{0, exp, -1, nm});
    @(posedge clk); #1 ard = 0;
  endtask
  task automatic a_start(input bit d, input int swaps, input int lat, input string nm);
    a_desc = d; a_ord = 1; ta0 = cyc + 1;
    qa.push_back('{1, swaps, lat, nm});
    @(posedge clk); #1 a_ord = 0;
  endtask
  task automatic a_wait(input string nm);
    for (int i = 0; i < 400 && !a_lis; i++) @(negedge clk);
    chk({nm, "_listo_seen"}, 32'(a_lis), 1);
    @(posedge clk); #1;
  endtask
  task automatic b_write(input int p, input int d);
    b_pos = 3'(p); b_dato = 8'(d); b_alm = 1;
    @(posedge clk); #1 b_alm = 0;
  endtask
  task automatic b_read(input int p, input int exp, input string nm);
    b_pos = 3'(p); brd = 1;
    qb.push_back('{0, exp, -1, nm});
    @(posedge clk); #1 brd = 0;
  endtask
  task automatic b_start(input int swaps, input int lat, input string nm);
    b_desc = 0; b_ord = 1; tb0 = cyc + 1;
    qb.push_back('{1, swaps, lat, nm});
    @(posedge clk); #1 b_ord = 0;
  endtask
  task automatic b_wait(input string nm);
    for (int i = 0; i < 100 && !b_lis; i++) @(negedge clk);
    chk({nm, "_listo_seen"}, 32'(b_lis), 1);
    @(posedge clk); #1;
  endtask
  int t4_in [16] = '{3, 7, 3, 1, 9, 0, 5, 5, 2, 8, 4, 6, 1, 7, 0, 9};
  int t4_out[16] = '{9, 9, 8, 7, 7, 6, 5, 5, 4, 3, 3, 2, 1, 1, 0, 0};
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ocupado", 32'(a_ocu), 0);
    chk("reset_listo", 32'(a_lis), 0);
    chk("reset_intercambios", 32'(a_cnt), 0);
    chk("reset_resultado", 32'(a_res), 0);
    rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) a_read(i, 0, "t1_read");
    for (int i = 0; i < 16; i++) a_write(i, 15 - i);
    a_start(0, 120, 121, "t2");
    chk("t2_busy", 32'(a_ocu), 1);
    a_wait("t2");
    chk("t2_idle_after", 32'(a_ocu), 0);
    for (int i = 0; i < 16; i++) a_read(i, i, "t2_read");
    chk("t2_count_held", 32'(a_cnt), 120);
    a_start(0, 0, 16, "t3");
    a_wait("t3");
    a_read(0, 0, "t3_read_first");
    a_read(15, 15, "t3_read_last");
    for (int i = 0; i < 16; i++) a_write(i, t4_in[i]);
    a_start(1, 61, -1, "t4");
    a_desc = 0;
    a_pos = 0; a_dato = 31; a_alm = 1; a_ord = 1;
    @(posedge clk); #1 a_alm = 0; a_ord = 0;
    a_wait("t4");
    for (int i = 0; i < 16; i++) a_read(i, t4_out[i], "t4_read");
    a_pos = 3; a_dato = 17; a_alm = 1; a_ord = 1;
    @(posedge clk); #1 a_alm = 0; a_ord = 0;
    chk("t5_write_wins_no_start", 32'(a_ocu), 0);
    a_read(3, 17, "t5_read_written");
    chk("t5_count_held", 32'(a_cnt), 61);
    for (int i = 0; i < 16; i++) a_write(i, 15 - i);
    a_ord = 1;
    @(posedge clk); #1 a_ord = 0;
    repeat (30) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("t6_abort_ocupado", 32'(a_ocu), 0);
    chk("t6_abort_count", 32'(a_cnt), 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) a_read(i, 0, "t6_read_cleared");
    for (int i = 0; i < 5; i++) b_write(i, 4 - i);
    b_write(6, 200);
    b_start(10, 11, "b2");
    b_wait("b2");
    for (int i = 0; i < 8; i++) b_read(i, (i < 5) ? i : 0, "b2_read");
    b_start(0, 5, "b3");
    b_wait("b3");
    for (int i = 0; i < 8; i++) b_read(i, (i < 5) ? i : 0, "b3_read");
    repeat (3) @(posedge clk);
    #1;
    chk("a_scoreboard_drained", qa.size(), 0);
    chk("b_scoreboard_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
